// File: rtl/hpu_pkg.sv
// Shared definitions for the HDC processing unit store path.
// Holds the hypervector geometry, the output beat geometry and the
// store_box serializer state encoding.
package hpu_pkg;

  localparam int DIM     = 1023;
  localparam int OUT_W   = 64;
  localparam int BEATS   = (DIM + 1) / OUT_W;
  localparam int BEAT_CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef logic [DIM:0] hv_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    DONE_LAST
  } box_state_t;

endpackage

// File: rtl/store_box_fifo.sv
// Vector buffer for store_box: DEPTH entries of one hypervector plus a
// last-tag bit each.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clr_i           synchronous clear (accelerator not running)
//   wr_i            push wr_data_i / wr_tag_i at the tail
//   rd_i            pop the head (rd_data_o / rd_tag_o show the head)
//   tag_set_i       set the tag on the newest entry (tail-1)
//   full_o          all entries occupied
//   almost_full_o   occupancy >= DEPTH-1
//   empty_o         no entries occupied
//   count_o         registered occupancy 0..DEPTH
module store_box_fifo
  import hpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_i,
  input  logic                   wr_i,
  input  hv_t                    wr_data_i,
  input  logic                   wr_tag_i,
  input  logic                   rd_i,
  output hv_t                    rd_data_o,
  output logic                   rd_tag_o,
  input  logic                   tag_set_i,
  output logic                   full_o,
  output logic                   almost_full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  hv_t             mem_q [DEPTH];
  logic [DEPTH-1:0] tag_q, tag_d;
  logic [PW-1:0]   wrPtr_q, wrPtr_d;
  logic [PW-1:0]   rdPtr_q, rdPtr_d;
  logic [PW-1:0]   tailPrev;
  logic [CW-1:0]   count_q, count_d;
  logic            doWr, doRd;

  // A pop in the same cycle frees the head, so a write while full is
  // still accepted when it coincides with a read.
  assign doRd     = rd_i & ~empty_o;
  assign doWr     = wr_i & (~full_o | doRd);
  assign tailPrev = wrPtr_q - PW'(1);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    tag_d   = tag_q;
    if (tag_set_i && !empty_o) begin
      tag_d[tailPrev] = 1'b1;
    end
    if (doWr) begin
      tag_d[wrPtr_q] = wr_tag_i;
      wrPtr_d        = wrPtr_q + PW'(1);
    end
    if (doRd) begin
      rdPtr_d = rdPtr_q + PW'(1);
    end
    case ({doWr, doRd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      tag_q   <= '0;
    end else if (clr_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      tag_q   <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      tag_q   <= tag_d;
    end
  end

  // Vector storage carries no reset so it maps onto block RAM; entries
  // are only read while the occupancy says they hold valid data.
  always_ff @(posedge clk) begin
    if (doWr) begin
      mem_q[wrPtr_q] <= wr_data_i;
    end
  end

  assign rd_data_o     = mem_q[rdPtr_q];
  assign rd_tag_o      = tag_q[rdPtr_q];
  assign full_o        = (count_q == CW'(DEPTH));
  assign almost_full_o = (count_q >= CW'(DEPTH - 1));
  assign empty_o       = (count_q == '0);
  assign count_o       = count_q;

endmodule

// File: rtl/store_box.sv
// Store box: buffers core_result vectors captured on store, then
// serializes each into OUT_W-bit beats on a valid/ready stream with
// put_last marking the end of a job.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   run               accelerator running; low clears synchronously
//   store             core_result valid this cycle
//   core_result       hypervector from the core
//   last              end-of-job pulse from the core
//   put_v/put_d       output beat valid / data (LS slice first)
//   put_last          final beat of the job
//   put_ready         downstream accepts the beat
//   full/almost_full  buffer occupancy flags for store throttling
//   overflow          sticky: a store was dropped because of full
module store_box
  import hpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             store,
  input  hv_t              core_result,
  input  logic             last,
  output logic             put_v,
  output logic [OUT_W-1:0] put_d,
  output logic             put_last,
  input  logic             put_ready,
  output logic             full,
  output logic             almost_full,
  output logic             overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  box_state_t         state_q, state_d;
  hv_t                shReg_q, shReg_d;
  logic [BEAT_CW-1:0] beatCnt_q, beatCnt_d;
  logic               shTag_q, shTag_d;
  logic               tagPending_q, tagPending_d;
  logic               overflow_q, overflow_d;

  hv_t                fifoRdData;
  logic               fifoRdTag;
  logic               fifoEmpty;
  logic [CW-1:0]      fifoCount;

  logic beatFire, finalFire, pop, storeAcc, lastAcc;
  logic tagFifo, tagShreg, emptyLast, shLive, popTag;

  store_box_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr_i         (~run),
    .wr_i          (store),
    .wr_data_i     (core_result),
    .wr_tag_i      (lastAcc),
    .rd_i          (pop),
    .rd_data_o     (fifoRdData),
    .rd_tag_o      (fifoRdTag),
    .tag_set_i     (tagFifo),
    .full_o        (full),
    .almost_full_o (almost_full),
    .empty_o       (fifoEmpty),
    .count_o       (fifoCount)
  );

  assign beatFire  = (state_q == SEND) & put_ready;
  assign finalFire = beatFire & (beatCnt_q == BEAT_CW'(BEATS - 1));
  assign pop       = ~fifoEmpty & ((state_q == IDLE) | finalFire);
  assign storeAcc  = store & (~full | pop);

  // At most one job tag is outstanding; a last that arrives while one
  // is pending is dropped. The tag goes to the newest live vector:
  // the one being stored now, else the buffer tail, else the vector in
  // the shift register if it still has beats left to send. With no
  // live vector a standalone zero beat carries put_last instead.
  assign lastAcc   = last & ~tagPending_q;
  assign shLive    = (state_q == SEND) & ~finalFire;
  assign tagFifo   = lastAcc & ~storeAcc & ~fifoEmpty;
  assign tagShreg  = lastAcc & ~storeAcc & fifoEmpty & shLive;
  assign emptyLast = lastAcc & ~storeAcc & fifoEmpty & ~shLive;

  // When the tail entry is also the head being popped this cycle, its
  // tag write would land in a freed slot, so forward it to the loader.
  assign popTag = fifoRdTag | (tagFifo & (fifoCount == CW'(1)));

  always_comb begin
    state_d      = state_q;
    shReg_d      = shReg_q;
    beatCnt_d    = beatCnt_q;
    shTag_d      = shTag_q;
    tagPending_d = tagPending_q;
    overflow_d   = overflow_q | (store & full & ~pop);

    if ((finalFire && shTag_q) || (state_q == DONE_LAST && put_ready)) begin
      tagPending_d = 1'b0;
    end
    if (lastAcc) begin
      tagPending_d = 1'b1;
    end

    // The head is popped and loaded on the same edge, so LOAD is never
    // occupied and the first beat is valid the cycle after the pop.
    case (state_q)
      IDLE: begin
        if (pop) begin
          shReg_d   = fifoRdData;
          shTag_d   = popTag;
          beatCnt_d = '0;
          state_d   = SEND;
        end else if (emptyLast) begin
          state_d = DONE_LAST;
        end
      end
      SEND: begin
        if (tagShreg) begin
          shTag_d = 1'b1;
        end
        if (finalFire) begin
          if (pop) begin
            shReg_d   = fifoRdData;
            shTag_d   = popTag;
            beatCnt_d = '0;
          end else begin
            shReg_d   = '0;
            shTag_d   = 1'b0;
            beatCnt_d = '0;
            state_d   = emptyLast ? DONE_LAST : IDLE;
          end
        end else if (beatFire) begin
          shReg_d   = shReg_q >> OUT_W;
          beatCnt_d = beatCnt_q + BEAT_CW'(1);
        end
      end
      DONE_LAST: begin
        if (put_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shReg_q      <= '0;
      beatCnt_q    <= '0;
      shTag_q      <= 1'b0;
      tagPending_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else if (!run) begin
      state_q      <= IDLE;
      shReg_q      <= '0;
      beatCnt_q    <= '0;
      shTag_q      <= 1'b0;
      tagPending_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shReg_q      <= shReg_d;
      beatCnt_q    <= beatCnt_d;
      shTag_q      <= shTag_d;
      tagPending_q <= tagPending_d;
      overflow_q   <= overflow_d;
    end
  end

  assign put_v    = (state_q == SEND) | (state_q == DONE_LAST);
  assign put_d    = (state_q == SEND) ? shReg_q[OUT_W-1:0] : '0;
  assign put_last = ((state_q == SEND) & shTag_q &
                     (beatCnt_q == BEAT_CW'(BEATS - 1))) |
                    (state_q == DONE_LAST);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_store_box.sv
// Directed self-checking bench for store_box with DEPTH=4.
// Inputs change and outputs are observed on the falling clock edge.
module tb_store_box;
  import hpu_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             run;
  logic             store;
  hv_t              core_result;
  logic             last;
  logic             put_v;
  logic [OUT_W-1:0] put_d;
  logic             put_last;
  logic             put_ready;
  logic             full;
  logic             almost_full;
  logic             overflow;

  int total = 0;
  int bad   = 0;

  logic [OUT_W-1:0] beatQ[$];
  logic             lastQ[$];

  store_box #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .store       (store),
    .core_result (core_result),
    .last        (last),
    .put_v       (put_v),
    .put_d       (put_d),
    .put_last    (put_last),
    .put_ready   (put_ready),
    .full        (full),
    .almost_full (almost_full),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: sim time limit reached, required finish");
    $fatal(1, "[TB] watchdog");
  end

  function automatic hv_t mkVec(input int base);
    hv_t v;
    v = '0;
    for (int i = 0; i < BEATS; i++) begin
      v[i*OUT_W +: OUT_W] = OUT_W'(base + i);
    end
    return v;
  endfunction

  // Logs the beat the coming rising edge will accept, then moves to the
  // next falling edge.
  task automatic cyc();
    if (put_v === 1'b1 && put_ready === 1'b1) begin
      beatQ.push_back(put_d);
      lastQ.push_back(put_last);
    end
    @(negedge clk);
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic clearQ();
    beatQ.delete();
    lastQ.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; store = 1'b0; last = 1'b0;
    put_ready = 1'b0; core_result = '0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({put_v, put_last, full, almost_full, overflow} !== 5'b0) begin
      bad++;
      $display("[TB] FAIL reset_flags: got v/l/f/af/ov=%b required 00000",
               {put_v, put_last, full, almost_full, overflow});
    end
    total++;
    if (put_d !== '0) begin
      bad++;
      $display("[TB] FAIL reset_data: got %h required 0", put_d);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    $display("[TB] single vector");
    clearQ();
    put_ready = 1'b1;
    store = 1'b1; core_result = mkVec(0);
    cyc();
    store = 1'b0;
    total++;
    if (put_v !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_lat1: put_v got %b required 0", put_v);
    end
    cyc();
    total++;
    if (put_v !== 1'b1) begin
      bad++;
      $display("[TB] FAIL single_lat2: put_v got %b required 1", put_v);
    end
    last = 1'b1;
    cyc();
    last = 1'b0;
    runCycles(30);
    total++;
    if (beatQ.size() != 16) begin
      bad++;
      $display("[TB] FAIL single_count: got %0d beats required 16", beatQ.size());
    end
    for (int i = 0; i < 16 && i < beatQ.size(); i++) begin
      total++;
      if (beatQ[i] !== OUT_W'(i) || lastQ[i] !== (i == 15)) begin
        bad++;
        $display("[TB] FAIL single_beat%0d: got %h/%b required %h/%b",
                 i, beatQ[i], lastQ[i], OUT_W'(i), (i == 15));
      end
    end
  endtask

  task automatic test_backpressure();
    logic             prevStall;
    logic [OUT_W-1:0] prevD;
    $display("[TB] backpressure");
    clearQ();
    prevStall = 1'b0;
    prevD = '0;
    for (int k = 0; k < 200; k++) begin
      store = (k < 3);
      core_result = mkVec(16 + 16 * k);
      put_ready = ((k % 3) == 0);
      if (prevStall) begin
        total++;
        if (put_v !== 1'b1 || put_d !== prevD) begin
          bad++;
          $display("[TB] FAIL bp_hold: got v=%b d=%h required v=1 d=%h",
                   put_v, put_d, prevD);
        end
      end
      prevStall = (put_v === 1'b1) && !put_ready;
      prevD = put_d;
      cyc();
    end
    store = 1'b0;
    total++;
    if (beatQ.size() != 48) begin
      bad++;
      $display("[TB] FAIL bp_count: got %0d beats required 48", beatQ.size());
    end
    for (int i = 0; i < 48 && i < beatQ.size(); i++) begin
      total++;
      if (beatQ[i] !== OUT_W'(16 + i) || lastQ[i] !== 1'b0) begin
        bad++;
        $display("[TB] FAIL bp_beat%0d: got %h/%b required %h/0",
                 i, beatQ[i], lastQ[i], OUT_W'(16 + i));
      end
    end
  endtask

  // The first vector is popped into the shift register straight away,
  // so the four-entry buffer fills on the fifth store and the sixth is
  // dropped; five vectors come out.
  task automatic test_overflow();
    $display("[TB] overflow");
    clearQ();
    put_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      store = 1'b1;
      core_result = mkVec(200 + 16 * k);
      cyc();
      if (k == 3) begin
        total++;
        if (almost_full !== 1'b1 || full !== 1'b0) begin
          bad++;
          $display("[TB] FAIL ovf_af: got af=%b f=%b required af=1 f=0",
                   almost_full, full);
        end
      end
      if (k == 4) begin
        total++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
          bad++;
          $display("[TB] FAIL ovf_full: got f=%b ov=%b required f=1 ov=0",
                   full, overflow);
        end
      end
      if (k == 5) begin
        total++;
        if (overflow !== 1'b1 || full !== 1'b1) begin
          bad++;
          $display("[TB] FAIL ovf_set: got ov=%b f=%b required ov=1 f=1",
                   overflow, full);
        end
      end
    end
    store = 1'b0;
    put_ready = 1'b1;
    runCycles(110);
    total++;
    if (beatQ.size() != 80) begin
      bad++;
      $display("[TB] FAIL ovf_count: got %0d beats required 80", beatQ.size());
    end
    for (int i = 0; i < 80 && i < beatQ.size(); i++) begin
      total++;
      if (beatQ[i] !== OUT_W'(200 + i)) begin
        bad++;
        $display("[TB] FAIL ovf_beat%0d: got %h required %h",
                 i, beatQ[i], OUT_W'(200 + i));
      end
    end
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ovf_sticky: got %b required 1", overflow);
    end
    run = 1'b0;
    cyc();
    run = 1'b1;
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ovf_clear: got %b required 0", overflow);
    end
  endtask

  task automatic test_empty_last();
    $display("[TB] empty last");
    clearQ();
    put_ready = 1'b0;
    last = 1'b1;
    cyc();
    last = 1'b0;
    total++;
    if (put_v !== 1'b1 || put_d !== '0 || put_last !== 1'b1) begin
      bad++;
      $display("[TB] FAIL elast_beat: got v=%b d=%h l=%b required 1/0/1",
               put_v, put_d, put_last);
    end
    cyc();
    total++;
    if (put_v !== 1'b1 || put_last !== 1'b1) begin
      bad++;
      $display("[TB] FAIL elast_hold: got v=%b l=%b required 1/1",
               put_v, put_last);
    end
    put_ready = 1'b1;
    cyc();
    total++;
    if (put_v !== 1'b0 || put_last !== 1'b0) begin
      bad++;
      $display("[TB] FAIL elast_idle: got v=%b l=%b required 0/0",
               put_v, put_last);
    end
    total++;
    if (beatQ.size() != 1) begin
      bad++;
      $display("[TB] FAIL elast_count: got %0d beats required 1", beatQ.size());
    end
  endtask

  task automatic test_store_last_and_pop();
    logic didStore;
    $display("[TB] store+last and store-on-pop");
    clearQ();
    put_ready = 1'b1;
    store = 1'b1; last = 1'b1; core_result = mkVec(300);
    cyc();
    store = 1'b0; last = 1'b0;
    runCycles(25);
    total++;
    if (beatQ.size() != 16) begin
      bad++;
      $display("[TB] FAIL sl_count: got %0d beats required 16", beatQ.size());
    end
    for (int i = 0; i < 16 && i < beatQ.size(); i++) begin
      total++;
      if (beatQ[i] !== OUT_W'(300 + i) || lastQ[i] !== (i == 15)) begin
        bad++;
        $display("[TB] FAIL sl_beat%0d: got %h/%b required %h/%b",
                 i, beatQ[i], lastQ[i], OUT_W'(300 + i), (i == 15));
      end
    end

    clearQ();
    put_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      store = 1'b1;
      core_result = mkVec(400 + 16 * k);
      cyc();
    end
    store = 1'b0;
    total++;
    if (full !== 1'b1) begin
      bad++;
      $display("[TB] FAIL pop_prefull: got %b required 1", full);
    end
    didStore = 1'b0;
    put_ready = 1'b1;
    for (int k = 0; k < 130; k++) begin
      if (!didStore && beatQ.size() == 15) begin
        total++;
        if (full !== 1'b1 || put_v !== 1'b1) begin
          bad++;
          $display("[TB] FAIL pop_full_at_store: got f=%b v=%b required 1/1",
                   full, put_v);
        end
        store = 1'b1;
        core_result = mkVec(480);
        didStore = 1'b1;
      end else begin
        store = 1'b0;
      end
      cyc();
    end
    store = 1'b0;
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("[TB] FAIL pop_ovf: got %b required 0", overflow);
    end
    total++;
    if (beatQ.size() != 96) begin
      bad++;
      $display("[TB] FAIL pop_count: got %0d beats required 96", beatQ.size());
    end
    for (int i = 0; i < 96 && i < beatQ.size(); i++) begin
      total++;
      if (beatQ[i] !== OUT_W'(400 + i) || lastQ[i] !== 1'b0) begin
        bad++;
        $display("[TB] FAIL pop_beat%0d: got %h/%b required %h/0",
                 i, beatQ[i], lastQ[i], OUT_W'(400 + i));
      end
    end
  endtask

  task automatic test_clear();
    int budget;
    $display("[TB] clear mid-transfer");
    clearQ();
    put_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      store = 1'b1;
      core_result = mkVec(600 + 16 * k);
      cyc();
    end
    store = 1'b0;
    total++;
    if (full !== 1'b1 || overflow !== 1'b1) begin
      bad++;
      $display("[TB] FAIL clr_pre: got f=%b ov=%b required 1/1", full, overflow);
    end
    put_ready = 1'b1;
    budget = 0;
    while (beatQ.size() < 7 && budget < 50) begin
      cyc();
      budget++;
    end
    total++;
    if (beatQ.size() != 7 || put_d !== OUT_W'(607)) begin
      bad++;
      $display("[TB] FAIL clr_reach7: got %0d beats d=%h required 7 d=%h",
               beatQ.size(), put_d, OUT_W'(607));
    end
    run = 1'b0;
    cyc();
    total++;
    if (put_v !== 1'b0 || put_last !== 1'b0 || full !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("[TB] FAIL clr_run: got v=%b l=%b f=%b ov=%b required 0000",
               put_v, put_last, full, overflow);
    end
    run = 1'b1;
    runCycles(3);
    total++;
    if (put_v !== 1'b0) begin
      bad++;
      $display("[TB] FAIL clr_empty: got put_v=%b required 0", put_v);
    end

    put_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      store = 1'b1;
      core_result = mkVec(700 + 16 * k);
      cyc();
    end
    store = 1'b0;
    total++;
    if (put_v !== 1'b1 || full !== 1'b1 || overflow !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rst_pre: got v=%b f=%b ov=%b required 111",
               put_v, full, overflow);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (put_v !== 1'b0 || put_last !== 1'b0 || full !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rst_async: got v=%b l=%b f=%b ov=%b required 0000",
               put_v, put_last, full, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_empty_last();
    test_store_last_and_pop();
    test_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
